// File: rtl/vga_scanout.sv
// VGA scan-out engine: raster counters, word-addressed framebuffer, palette lookup
// and a four-stage pipeline that keeps syncs aligned with the colour outputs.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int BPP      = 1,
  parameter int UPSCALE  = 1,
  localparam int FB_W    = H_ACTIVE / UPSCALE,
  localparam int FB_H    = V_ACTIVE / UPSCALE,
  localparam int WPL     = FB_W * BPP / 32,
  localparam int DEPTH   = WPL * FB_H,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic          fb_we_i,
  input  logic [AW-1:0] fb_addr_i,
  input  logic [31:0]   fb_wdata_i,
  input  logic          pal_we_i,
  input  logic [BPP-1:0] pal_idx_i,
  input  logic [11:0]   pal_wdata_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic [3:0]    r_o,
  output logic [3:0]    g_o,
  output logic [3:0]    b_o,
  output logic          frame_start_o,
  output logic          vblank_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int UW      = (UPSCALE > 1) ? $clog2(UPSCALE) : 1;
  localparam int PPW     = 32 / BPP;
  localparam int PW      = $clog2(PPW);
  localparam int LB      = $clog2(BPP);
  localparam int NPAL    = 1 << BPP;
  localparam logic SP    = SYNC_POL;

  if ((H_ACTIVE % UPSCALE) != 0 || (V_ACTIVE % UPSCALE) != 0) begin : g_bad_upscale
    $error("vga_scanout: active area not divisible by UPSCALE");
  end
  if (BPP != 1 && BPP != 2 && BPP != 4 && BPP != 8) begin : g_bad_bpp
    $error("vga_scanout: BPP must be 1, 2, 4 or 8");
  end
  if (((FB_W * BPP) % 32) != 0) begin : g_bad_line
    $error("vga_scanout: framebuffer line is not a whole number of words");
  end

  // ---------------- S0: raster counters and incremental address ----------------
  logic [HW-1:0] sx_q, sx_d;
  logic [VW-1:0] sy_q, sy_d;
  logic [UW-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [PW-1:0] p_q, p_d;
  logic [AW-1:0] addr_q, addr_d, base_q, base_d;

  always_comb begin
    sx_d   = sx_q + 1'b1;
    sy_d   = sy_q;
    rx_d   = rx_q;
    ry_d   = ry_q;
    p_d    = p_q;
    addr_d = addr_q;
    base_d = base_q;
    // Each logical pixel repeats UPSCALE clocks; a word holds PPW logical pixels.
    if (rx_q == UW'(UPSCALE - 1)) begin
      rx_d = '0;
      if (p_q == PW'(PPW - 1)) begin
        p_d    = '0;
        addr_d = addr_q + 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end else begin
      rx_d = rx_q + 1'b1;
    end
    if (sx_q == HW'(H_TOTAL - 1)) begin
      sx_d = '0;
      rx_d = '0;
      p_d  = '0;
      if (sy_q == VW'(V_TOTAL - 1)) begin
        sy_d   = '0;
        ry_d   = '0;
        base_d = '0;
      end else begin
        sy_d = sy_q + 1'b1;
        if (ry_q == UW'(UPSCALE - 1)) begin
          ry_d   = '0;
          base_d = base_q + AW'(WPL);
        end else begin
          ry_d = ry_q + 1'b1;
        end
      end
      addr_d = base_d;
    end
  end

  logic de0, hs0, vs0, fs0, vb0;
  assign de0 = (sx_q < HW'(H_ACTIVE)) && (sy_q < VW'(V_ACTIVE));
  assign hs0 = ((sx_q >= HW'(H_ACTIVE + H_FP)) && (sx_q < HW'(H_ACTIVE + H_FP + H_SYNC))) ? SP : ~SP;
  assign vs0 = ((sy_q >= VW'(V_ACTIVE + V_FP)) && (sy_q < VW'(V_ACTIVE + V_FP + V_SYNC))) ? SP : ~SP;
  assign fs0 = (sx_q == '0) && (sy_q == '0);
  assign vb0 = (sy_q >= VW'(V_ACTIVE));

  // ---------------- S1: framebuffer (no reset on contents) ----------------
  // Write ports are single-cycle strobes with no backpressure: a write is taken
  // on any clock edge where the strobe is high.
  logic [31:0] fb_mem [DEPTH];
  logic [31:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (fb_we_i && (32'(fb_addr_i) < 32'(DEPTH))) begin
      fb_mem[fb_addr_i] <= fb_wdata_i;
    end
    rd_q <= fb_mem[addr_q];
  end

  logic          de1_q, hs1_q, vs1_q, fs1_q, vb1_q;
  logic [PW-1:0] p1_q;

  // ---------------- S2: field select and palette ----------------
  logic [4:0]     sh;
  logic [BPP-1:0] field;
  assign sh    = 5'(p1_q) << LB;
  assign field = BPP'(rd_q >> sh);

  logic [11:0] pal_q [NPAL];
  logic [11:0] pal_rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NPAL; i++) begin
        pal_q[i] <= (i == 0) ? 12'h000 : 12'hFFF;
      end
      pal_rd_q <= '0;
    end else begin
      if (pal_we_i) pal_q[pal_idx_i] <= pal_wdata_i;
      pal_rd_q <= pal_q[field];
    end
  end

  logic de2_q, hs2_q, vs2_q, fs2_q, vb2_q;

  // ---------------- S3: output registers ----------------
  logic        hs3_q, vs3_q, fs3_q, vb3_q;
  logic [11:0] rgb3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sx_q   <= '0;
      sy_q   <= '0;
      rx_q   <= '0;
      ry_q   <= '0;
      p_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= ~SP;
      vs1_q  <= ~SP;
      fs1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      p1_q   <= '0;
      de2_q  <= 1'b0;
      hs2_q  <= ~SP;
      vs2_q  <= ~SP;
      fs2_q  <= 1'b0;
      vb2_q  <= 1'b0;
      hs3_q  <= ~SP;
      vs3_q  <= ~SP;
      fs3_q  <= 1'b0;
      vb3_q  <= 1'b0;
      rgb3_q <= '0;
    end else begin
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      rx_q   <= rx_d;
      ry_q   <= ry_d;
      p_q    <= p_d;
      addr_q <= addr_d;
      base_q <= base_d;
      de1_q  <= de0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      fs1_q  <= fs0;
      vb1_q  <= vb0;
      p1_q   <= p_q;
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      fs2_q  <= fs1_q;
      vb2_q  <= vb1_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      fs3_q  <= fs2_q;
      vb3_q  <= vb2_q;
      rgb3_q <= (de2_q && enable_i) ? pal_rd_q : 12'h000;
    end
  end

  assign hsync_o       = hs3_q;
  assign vsync_o       = vs3_q;
  assign r_o           = rgb3_q[11:8];
  assign g_o           = rgb3_q[7:4];
  assign b_o           = rgb3_q[3:0];
  assign frame_start_o = fs3_q;
  assign vblank_o      = vb3_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster (2 bpp, 2x upscale): a driver pushes
// expected outputs from a pixel-arithmetic model, a monitor pops and compares.
module tb_vga_scanout;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 2;
  localparam bit POL = 1'b0;
  localparam int BPP = 2, U = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int FBW = HA / U;
  localparam int WPL = FBW * BPP / 32;
  localparam int DEPTH = WPL * (VA / U);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] RST_OUT = {~POL, ~POL, 12'h000, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           enable, fb_we, pal_we;
  logic [AW-1:0]  fb_addr;
  logic [31:0]    fb_wdata;
  logic [BPP-1:0] pal_idx;
  logic [11:0]    pal_wdata;
  logic           hsync, vsync, frame_start, vblank;
  logic [3:0]     r, g, b;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .BPP(BPP), .UPSCALE(U)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .fb_we_i(fb_we), .fb_addr_i(fb_addr), .fb_wdata_i(fb_wdata),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_wdata_i(pal_wdata),
    .hsync_o(hsync), .vsync_o(vsync), .r_o(r), .g_o(g), .b_o(b),
    .frame_start_o(frame_start), .vblank_o(vblank)
  );

  // ---------------- reference model ----------------
  logic [31:0] fb_m [DEPTH];
  logic [11:0] pal_m [1 << BPP];
  logic [15:0] exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int n_mon = 0;
  bit running = 1'b0;
  int c;
  int fld_a;
  logic [11:0] col_b;

  function automatic int word_of(int pos);
    int sx, sy;
    sx = pos % HT;
    sy = (pos / HT) % VT;
    return (sy / U) * WPL + ((sx / U) * BPP) / 32;
  endfunction

  function automatic int field_of(int pos);
    int sx, sy, fx;
    sx = pos % HT;
    sy = (pos / HT) % VT;
    if (!(sx < HA && sy < VA)) return 0;
    fx = sx / U;
    return int'((fb_m[word_of(pos)] >> ((fx % (32 / BPP)) * BPP)) & ((32'd1 << BPP) - 32'd1));
  endfunction

  function automatic logic [15:0] expect_out(int pos, logic [11:0] col, logic en);
    int sx, sy;
    logic hs, vs, de, fs, vb;
    sx = pos % HT;
    sy = (pos / HT) % VT;
    de = (sx < HA) && (sy < VA);
    hs = (sx >= HA + HFP && sx < HA + HFP + HS) ? POL : ~POL;
    vs = (sy >= VA + VFP && sy < VA + VFP + VS) ? POL : ~POL;
    fs = (sx == 0) && (sy == 0);
    vb = (sy >= VA);
    return {hs, vs, (de && en) ? col : 12'h000, fs, vb};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (sample %0d, t=%0t)", name, act, exp_v, n_mon, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (running) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry (sample %0d)", n_mon);
      end else begin
        check("pixel_out", {hsync, vsync, r, g, b, frame_start, vblank}, exp_q.pop_front());
      end
      n_mon++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    fb_we = 1'b0;
    pal_we = 1'b0;
    fb_addr = '0;
    fb_wdata = '0;
    pal_idx = '0;
    pal_wdata = '0;
  endtask

  task automatic step();
    if ($urandom_range(0, 199) == 0) enable = ~enable;
    fb_we = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 3) == 0) fb_addr = AW'(word_of(c));
    else fb_addr = AW'($urandom_range(0, (1 << AW) - 1));
    fb_wdata = $urandom;
    pal_we = ($urandom_range(0, 15) == 0);
    pal_idx = BPP'($urandom_range(0, (1 << BPP) - 1));
    pal_wdata = 12'($urandom);
    if (c >= 2) exp_q.push_back(expect_out(c - 2, col_b, enable));
    else exp_q.push_back(RST_OUT);
    if (c >= 1) col_b = pal_m[fld_a];
    fld_a = field_of(c);
    if (fb_we && int'(fb_addr) < DEPTH) fb_m[fb_addr] = fb_wdata;
    if (pal_we) pal_m[pal_idx] = pal_wdata;
    c++;
  endtask

  task automatic start_scan();
    rst_n = 1'b1;
    c = 0;
    fld_a = 0;
    col_b = '0;
    for (int i = 0; i < (1 << BPP); i++) pal_m[i] = (i == 0) ? 12'h000 : 12'hFFF;
    exp_q.delete();
    exp_q.push_back(RST_OUT);
    running = 1'b1;
  endtask

  task automatic run_until(input int target);
    while (c < target) begin
      step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mid_reset(input string name);
    running = 1'b0;
    rst_n = 1'b0;
    drive_idle();
    #1;
    check(name, {hsync, vsync, r, g, b, frame_start, vblank}, RST_OUT);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check({name, "_held"}, {hsync, vsync, r, g, b, frame_start, vblank}, RST_OUT);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {hsync, vsync, r, g, b, frame_start, vblank}, RST_OUT);
    for (int a = 0; a < DEPTH; a++) begin
      fb_we = 1'b1;
      fb_addr = AW'(a);
      fb_wdata = (a == 0) ? 32'h0000_00E4 : $urandom;
      fb_m[a] = fb_wdata;
      @(posedge clk);
      #1;
    end
    drive_idle();
    @(posedge clk);
    #1;
    start_scan();
    run_until(2 * FRAME + 5 * HT + 20);
    mid_reset("reset_in_active");
    start_scan();
    run_until((VA + VFP) * HT + HA + HFP + 4);
    mid_reset("reset_in_sync");
    start_scan();
    run_until(FRAME + 10);
    drive_idle();
    @(negedge clk);
    #1;
    running = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine with an internal word-addressed framebuffer, a writable colour palette and an integer upscale factor. It generalises the fixed 640x480 1-bpp monochrome display to configurable timing, 1/2/4/8 bits per pixel and a palette. It also adds frame and vblank status for the CPU. It sits between the core's store path, which drives the framebuffer and palette write ports, and the board VGA pins. The whole block runs on the pixel clock.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in clocks
- V_ACTIVE, 480, active lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches / sync in lines
- SYNC_POL, 0, sync asserted level (0 = negative polarity)
- BPP, 1, bits per pixel, one of 1/2/4/8
- UPSCALE, 1, integer pixel replication factor in x and y, ≥1
- Derived: FB_W = H_ACTIVE/UPSCALE, FB_H = V_ACTIVE/UPSCALE, WPL = FB_W*BPP/32 words per line, DEPTH = WPL*FB_H, AW = clog2(DEPTH)
- Elaboration error if H_ACTIVE or V_ACTIVE is not divisible by UPSCALE, or if FB_W*BPP is not a multiple of 32.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  1 = show framebuffer; 0 = blank RGB (syncs keep running)
- fb_we  in  1  framebuffer word write strobe
- fb_addr  in  AW  word address
- fb_wdata  in  32  write data
- pal_we  in  1  palette write strobe
- pal_idx  in  BPP  palette entry
- pal_wdata  in  12  {r,g,b} 4 bits each
- hsync, vsync  out  1  sync outputs
- r, g, b  out  4  colour outputs
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the outputs
- vblank  out  1  high while the output-aligned line is ≥ V_ACTIVE

## Operation
- Counters: sx runs 0..H_TOTAL-1 and sy runs 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is defined likewise.
  - sx increments every clock.
  - sy increments when sx wraps.
  - Both wrap to 0 after (H_TOTAL-1, V_TOTAL-1).
- Sync: hsync = SYNC_POL when sx ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~SYNC_POL. vsync uses the same rule on sy.
- Active region: de = sx<H_ACTIVE && sy<V_ACTIVE.
- Logical pixel: fx = sx/UPSCALE, fy = sy/UPSCALE.
  - Fetch word = fy*WPL + fx*BPP/32.
  - Pixel is bits [p*BPP +: BPP] with p = fx mod (32/BPP), LSB first.
  - Address generation uses incrementing replicate/line counters; no dividers or multipliers in RTL.
- Pipeline, four stages:
  - S0: counter and address.
  - S1: synchronous framebuffer read.
  - S2: pixel field select and palette read.
  - S3: output registers.
  - hsync, vsync, de, frame_start and vblank are delayed so they stay aligned with RGB.
- Output: {r,g,b} = (de && enable) ? palette[field] : 0.
- Framebuffer write: on fb_we with fb_addr < DEPTH, store the word at the clock edge. Writes with fb_addr ≥ DEPTH are ignored.
- Palette write: on pal_we, update the entry at the clock edge. It affects any S2 lookup on later cycles. Mid-frame tearing is permitted.
- Palette reset: entry 0 = 12'h000, all other entries = 12'hFFF. For BPP=1 this gives black/white by default. Framebuffer contents are not reset.

## Timing
- Output latency is 3 clocks: the outputs in cycle n reflect counter state (sx,sy) from cycle n-3.
- Counters at the first rising edge after rst deasserts are (0,0).
- Reset values, applied asynchronously:
  - sx = sy = 0; pipeline flushed to blank.
  - hsync = vsync = ~SYNC_POL.
  - r = g = b = 0.
  - frame_start = 0, vblank = 0.
- frame_start is high for exactly 1 clock per frame. The first pulse after reset is at cycle 3.
- vblank rises at output line V_ACTIVE, column 0, and falls at output line 0, column 0.
- Read/write collision (fb_we to the address S1 reads in the same cycle): the read returns the old word. Palette collisions behave the same way.
- Reset asserted mid-line: all outputs go to reset values immediately. Scan restarts from (0,0) with no partial-frame frame_start.
- enable toggling takes effect at the S3 register, i.e. on the next clock edge.

## Test plan
- Defaults, with outputs idle after reset:
  - hsync low for 96 clocks starting at cycle 3+656.
  - Line period 800; vsync low for 2 lines starting at line 490.
  - frame_start every 420000 clocks.
  - RGB 0 outside the active region.
- Defaults, fb word 0 = 32'h0000_0001:
  - Output pixel (0,0) = F,F,F; pixels (1,0) through (31,0) = 0,0,0.
  - Word 20 bit 0 maps to pixel (0,1).
- BPP=4:
  - Palette entry 5 = 12'hA5C and word 0 = 32'h0000_0050 → pixel 1 = r A, g 5, b C; pixel 0 = 0,0,0.
- UPSCALE=2, word 0 bit 0 = 1:
  - Pixels (0,0), (1,0), (0,1), (1,1) are white; pixels (2,0) and (0,2) are black.
  - WPL = 10.
- Boundary writes:
  - fb_addr = DEPTH write is ignored, and word 0 is unchanged.
  - Same-cycle write/read of one address outputs the old data, and the new data appears on the next frame.
- Reset and enable:
  - rst low at sx=300, sy=100 → outputs immediately hsync = vsync = 1, RGB = 0. After release, the first frame_start comes 3 cycles later.
  - enable = 0 → RGB 0 while sync timing is unchanged.
